// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder/subtractor, one full-adder cell, LSB first
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic             busy_q;
   logic             done_q;
   logic             c_out_q;
   logic             ovf_q;

   logic             bit_a;
   logic             bit_b;
   logic             sum_bit_d;
   logic             carry_d;
   logic             last_bit;

   // The single full-adder cell: the counter selects which operand bit it sees.
   always_comb begin
      bit_a     = a_q[cnt_q];
      bit_b     = b_q[cnt_q];
      sum_bit_d = bit_a ^ bit_b ^ carry_q;
      carry_d   = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
      last_bit  = (cnt_q == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  // Subtraction is A + ~B + 1, so B is inverted and the carry preset here.
                  a_q     <= a;
                  b_q     <= b ^ {WIDTH{sub}};
                  carry_q <= sub ? 1'b1 : c_in;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               sum_q[cnt_q] <= sum_bit_d;
               carry_q      <= carry_d;
               if (last_bit) begin
                  c_out_q <= carry_d;
                  ovf_q   <= carry_q ^ carry_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign sum   = sum_q;
   assign c_out = c_out_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - checks serial_adder at WIDTH=8 (directed) and WIDTH=3 (exhaustive)
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, start3;
   logic [7:0] a8, b8;
   logic [2:0] a3, b3;
   logic       ci8, sb8, ci3, sb3;
   logic       busy8, done8, cout8, ovf8;
   logic [7:0] sum8;
   logic       busy3, done3, cout3, ovf3;
   logic [2:0] sum3;

   int pass_cnt = 0;
   int total    = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(ci8), .sub(sb8),
      .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8), .ovf(ovf8)
   );

   serial_adder #(.WIDTH(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .c_in(ci3), .sub(sb3),
      .busy(busy3), .done(done3), .sum(sum3), .c_out(cout3), .ovf(ovf3)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference arithmetic: returns {ovf, c_out, sum[7:0]} for a w-bit operation.
   function automatic logic [9:0] ref_op(input int w, input logic [7:0] a, input logic [7:0] b,
                                         input logic ci, input logic sb);
      longint mask, ua, ub, c0, tot, half, sa, sbv, st;
      logic [7:0] s;
      logic co, ov;
      mask = (longint'(1) << w) - 1;
      ua   = longint'(a) & mask;
      ub   = sb ? (~longint'(b)) & mask : longint'(b) & mask;
      c0   = (sb || ci) ? 1 : 0;
      tot  = ua + ub + c0;
      s    = 8'(tot & mask);
      co   = ((tot >> w) & 1) != 0;
      half = longint'(1) << (w - 1);
      sa   = (ua >= half) ? ua - (mask + 1) : ua;
      sbv  = (ub >= half) ? ub - (mask + 1) : ub;
      st   = sa + sbv + c0;
      ov   = (st < -half) || (st > half - 1);
      return {ov, co, s};
   endfunction

   // Timeline model: accept at edge k -> busy in cycles k..k+w-1, done in cycle k+w.
   int         e = 0;
   bit         armed = 0;
   bit         pend[2];
   int         acc_k[2];
   logic [9:0] pres[2];
   logic [7:0] es[2];
   logic       ec[2], eo[2], eb[2], ed[2];
   int         mw;
   logic       ms, mc, msb;
   logic [7:0] ma, mb;
   bit         was_busy;

   initial begin
      for (int u = 0; u < 2; u++) begin
         pend[u] = 0; acc_k[u] = 0; pres[u] = '0; es[u] = '0;
         ec[u] = 0; eo[u] = 0; eb[u] = 0; ed[u] = 0;
      end
   end

   always @(posedge clk) begin
      e = e + 1;
      if (rst) armed = 1;
      for (int u = 0; u < 2; u++) begin
         mw  = (u == 0) ? 8 : 3;
         ms  = (u == 0) ? start8 : start3;
         ma  = (u == 0) ? a8 : {5'b0, a3};
         mb  = (u == 0) ? b8 : {5'b0, b3};
         mc  = (u == 0) ? ci8 : ci3;
         msb = (u == 0) ? sb8 : sb3;
         was_busy = pend[u] && (e - 1 >= acc_k[u]) && (e - 1 < acc_k[u] + mw);
         if (rst) begin
            pend[u] = 0; es[u] = '0; ec[u] = 0; eo[u] = 0;
         end else begin
            if (pend[u] && e == acc_k[u] + mw) {eo[u], ec[u], es[u]} = pres[u];
            if (ms && !was_busy) begin
               pend[u]  = 1;
               acc_k[u] = e;
               pres[u]  = ref_op(mw, ma, mb, mc, msb);
            end
         end
         eb[u] = pend[u] && (e >= acc_k[u]) && (e < acc_k[u] + mw);
         ed[u] = pend[u] && (e == acc_k[u] + mw);
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("busy8", busy8, eb[0]);
         chk("done8", done8, ed[0]);
         if (!eb[0]) begin
            chk("sum8", sum8, es[0]);
            chk("cout8", cout8, ec[0]);
            chk("ovf8", ovf8, eo[0]);
         end
         chk("busy3", busy3, eb[1]);
         chk("done3", done3, ed[1]);
         if (!eb[1]) begin
            chk("sum3", {5'b0, sum3}, es[1]);
            chk("cout3", cout3, ec[1]);
            chk("ovf3", ovf3, eo[1]);
         end
      end
   end

   task automatic wait_done8(input int n0, output int n);
      n = n0;
      while (!done8 && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb,
                      input logic [9:0] lit);
      int n;
      chk("ref8", ref_op(8, a, b, ci, sb), lit);
      a8 = a; b8 = b; ci8 = ci; sb8 = sb; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); sb8 = 1'($urandom);
      wait_done8(0, n);
      chk("latency8", n, 8);
      chk("result8", {ovf8, cout8, sum8}, lit);
   endtask

   initial begin
      int n, cnt;
      rst = 1'b1; start8 = 0; start3 = 0;
      a8 = 0; b8 = 0; ci8 = 0; sb8 = 0; a3 = 0; b3 = 0; ci3 = 0; sb3 = 0;
      repeat (2) @(negedge clk);
      chk("rst_sum8", sum8, 8'h00);
      chk("rst_busy8", busy8, 1'b0);
      rst = 1'b0;

      op8(8'h5A, 8'h3C, 1'b0, 1'b0, {1'b1, 1'b0, 8'h96});
      op8(8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00});
      op8(8'hFF, 8'hFF, 1'b1, 1'b0, {1'b0, 1'b1, 8'hFF});
      op8(8'h10, 8'h20, 1'b0, 1'b1, {1'b0, 1'b0, 8'hF0});
      op8(8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F});
      @(negedge clk);
      op8(8'h00, 8'h00, 1'b1, 1'b0, {1'b0, 1'b0, 8'h01});
      op8(8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80});
      @(negedge clk);

      // start re-pulsed mid-operation must be ignored
      a8 = 8'h12; b8 = 8'h34; ci8 = 0; sb8 = 0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (2) @(negedge clk);
      a8 = 8'hFF; b8 = 8'hFF; ci8 = 1; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      wait_done8(3, n);
      chk("latency_ign", n, 8);
      chk("result_ign", {ovf8, cout8, sum8}, {1'b0, 1'b0, 8'h46});
      @(negedge clk);

      // reset during RUN cycle 4 abandons the operation
      a8 = 8'h5A; b8 = 8'h3C; ci8 = 0; sb8 = 0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_run_out", {busy8, done8, ovf8, cout8, sum8}, 12'h000);
      cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8) cnt++;
      end
      chk("no_done_after_rst", cnt, 0);
      op8(8'h01, 8'h02, 1'b0, 1'b0, {1'b0, 1'b0, 8'h03});
      @(negedge clk);

      // WIDTH=3 exhaustive with start held through DONE
      chk("ref3_a", ref_op(3, 8'd7, 8'd1, 1'b0, 1'b0), {1'b0, 1'b1, 8'd0});
      chk("ref3_b", ref_op(3, 8'd3, 8'd1, 1'b0, 1'b0), {1'b1, 1'b0, 8'd4});
      {sb3, ci3, b3, a3} = 8'd0;
      start3 = 1'b1;
      @(negedge clk);
      for (int i = 1; i < 257; i++) begin
         n = 0;
         while (!done3 && n < 10) begin
            @(negedge clk);
            n++;
         end
         chk("period3", n + 1, 4);
         if (i == 256) start3 = 1'b0;
         else {sb3, ci3, b3, a3} = 8'(i);
         @(negedge clk);
      end
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
